io_handler: RTL and testbench
=============================

Name: io_handler

Overview:
User I/O front end of the MITM board. It debounces the mode-select push button and cycles a one-hot operating-mode register on each debounced press. It drives mode LEDs mirroring the mode, plus a pulse-stretched "communication active" LED. It sits between the board pins and the core mode-dispatch logic; everything runs in the sys_clk domain.

Parameters:
MODE_WIDTH, 4, number of modes; width of the one-hot mode register (>=2).
BUTTON_ACTIVE_LOW, 1, 1: raw button reads 0 when pressed; 0: reads 1 when pressed.
DEBOUNCE_COUNT, 8, consecutive stable sys_clk cycles required to accept a button level change (>=1).
COMM_LED_HOLD, 1_200_000, extra cycles comm_active_led stays lit after comm_active falls (0 = no stretch).

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
sys_rst  input  1  synchronous, active-high reset.
mode_select_btn  input  1  raw, asynchronous, bouncy button pin.
comm_active  input  1  sys_clk-synchronous flag, high while a bus transfer is in progress.
mode_select  output  MODE_WIDTH  one-hot current mode, registered.
mode_leds  output  MODE_WIDTH  LED drive, identical to mode_select.
comm_active_led  output  1  stretched activity LED, registered.

Behaviour:
- Reset (sys_rst high at a rising edge) sets every register:
  - mode_select = 1 (bit 0 only); mode_leds follows.
  - comm_active_led = 0; hold counter = 0; debounce counter = 0.
  - Both synchronizer flops = released level; debounced state = released.
- Reset takes priority over all other updates, including mid-press or mid-stretch.
- Input conditioning:
  - Two-flop synchronizer on mode_select_btn.
  - Synchronized level normalised to pressed=1 (inverted when BUTTON_ACTIVE_LOW=1).
- Debounce:
  - Counter width clog2(DEBOUNCE_COUNT+1).
  - Each cycle the normalised level differs from the debounced state, the counter increments.
  - Any cycle it equals the debounced state, the counter clears to 0.
  - When the level has differed for DEBOUNCE_COUNT consecutive cycles, the debounced state toggles on that edge and the counter clears.
  - Bounce shorter than DEBOUNCE_COUNT cycles never changes the debounced state.
- Latency: raw pin stable from just before edge k -> debounced state and mode change at edge k+1+DEBOUNCE_COUNT (edge k+9 with defaults).
- Mode stepping:
  - On the edge where the debounced state goes released->pressed, mode_select rotates left by one: bit MODE_WIDTH-1 wraps to bit 0.
  - Release causes no change.
  - Holding the button gives exactly one step; no auto-repeat.
  - mode_select is always exactly one-hot.
- Activity LED:
  - If comm_active = 1: hold counter loads COMM_LED_HOLD and comm_active_led <= 1.
  - Else if hold counter != 0: counter decrements and comm_active_led <= 1.
  - Else comm_active_led <= 0.
  - Result: LED rises 1 cycle after comm_active rises and stays high for COMM_LED_HOLD cycles after comm_active's last high cycle.
  - COMM_LED_HOLD=0 gives a plain 1-cycle-delayed copy.
- The button path and the LED path are independent; simultaneous events are both processed.

Test Plan:
- Reset: assert sys_rst 2 cycles with button released -> mode_select=mode_leds=4'b0001, comm_active_led=0.
- Clean press: drive button low at edge k, hold 20 cycles -> mode_select stays 0001 through edge k+8 and becomes 0010 at edge k+9. Release -> remains 0010.
- Bounce rejection: toggle the pin with random 1-7 cycle pulses, then settle released -> mode unchanged. Then a noisy press (bursts <8 cycles, then 8+ cycle stable low, noisy release) -> exactly one step.
- Wrap: 9 debounced presses from reset -> sequence 0010, 0100, 1000, 0001, 0010, 0100, 1000, 0001, 0010; final 0010.
- Long hold: hold pressed 1000 cycles -> exactly one step. Reset asserted mid-hold -> 0001, with no step at release or while still held.
- Activity LED with COMM_LED_HOLD=3: comm_active high 4 cycles -> comm_active_led high from 1 cycle after the rise until 3 cycles after the fall, then 0. With COMM_LED_HOLD=0 -> LED high exactly 4 cycles, delayed by 1.

Source files
------------

// File: rtl/io_handler.sv
// User I/O front end: debounced mode-select button stepping a one-hot mode
// register, mode LEDs, and a pulse-stretched communication-activity LED.
module io_handler #(
    parameter int unsigned MODE_WIDTH        = 4,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
    parameter int unsigned DEBOUNCE_COUNT    = 8,
    parameter int unsigned COMM_LED_HOLD     = 1_200_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  mode_select_btn,
    input  logic                  comm_active,
    output logic [MODE_WIDTH-1:0] mode_select,
    output logic [MODE_WIDTH-1:0] mode_leds,
    output logic                  comm_active_led
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_COUNT + 1);
    localparam int unsigned HOLD_W = (COMM_LED_HOLD > 0) ? $clog2(COMM_LED_HOLD + 1) : 1;

    localparam logic              BTN_RELEASED = BUTTON_ACTIVE_LOW;
    localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD    = HOLD_W'(COMM_LED_HOLD);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  db_q, db_d;
    logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  led_q, led_d;

    logic                  btn_pressed;
    logic                  press_edge;

    // Synchronize, normalise to pressed=1, debounce, and step the mode.
    always_comb begin
        sync1_d     = mode_select_btn;
        sync2_d     = sync1_q;
        btn_pressed = sync2_q ^ BUTTON_ACTIVE_LOW;
        db_d        = db_q;
        db_cnt_d    = '0;

        if (btn_pressed != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        press_edge = db_d & ~db_q;
        mode_d     = mode_q;
        if (press_edge) begin
            mode_d = {mode_q[MODE_WIDTH-2:0], mode_q[MODE_WIDTH-1]};
        end
    end

    // Activity LED: reload on activity, count down the stretch afterwards.
    always_comb begin
        hold_d = hold_q;
        led_d  = 1'b0;
        if (comm_active) begin
            hold_d = HOLD_LOAD;
            led_d  = 1'b1;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
            led_d  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q  <= BTN_RELEASED;
            sync2_q  <= BTN_RELEASED;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            mode_q   <= MODE_WIDTH'(1);
            hold_q   <= '0;
            led_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            mode_q   <= mode_d;
            hold_q   <= hold_d;
            led_q    <= led_d;
        end
    end

    assign mode_select     = mode_q;
    assign mode_leds       = mode_q;
    assign comm_active_led = led_q;

endmodule

// File: tb/tb_io_handler.sv
// Directed bench for io_handler: two instances share stimulus, one with a
// 3-cycle LED stretch and one with no stretch.
module tb_io_handler;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       comm;
    logic [3:0] mode_a, leds_a, mode_b, leds_b;
    logic       led_a, led_b;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    io_handler #(
        .MODE_WIDTH(4), .BUTTON_ACTIVE_LOW(1'b1), .DEBOUNCE_COUNT(8), .COMM_LED_HOLD(3)
    ) dut_a (
        .sys_clk(clk), .sys_rst(rst), .mode_select_btn(btn), .comm_active(comm),
        .mode_select(mode_a), .mode_leds(leds_a), .comm_active_led(led_a)
    );

    io_handler #(
        .MODE_WIDTH(4), .BUTTON_ACTIVE_LOW(1'b1), .DEBOUNCE_COUNT(8), .COMM_LED_HOLD(0)
    ) dut_b (
        .sys_clk(clk), .sys_rst(rst), .mode_select_btn(btn), .comm_active(comm),
        .mode_select(mode_b), .mode_leds(leds_b), .comm_active_led(led_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mode(input string tag, input logic [3:0] exp);
        n_checks++;
        assert (mode_a === exp) else begin
            n_fails++;
            $error("FAIL %s mode_select: observed %b expected %b", tag, mode_a, exp);
        end
        n_checks++;
        assert (leds_a === exp) else begin
            n_fails++;
            $error("FAIL %s mode_leds: observed %b expected %b", tag, leds_a, exp);
        end
        n_checks++;
        assert (mode_b === exp) else begin
            n_fails++;
            $error("FAIL %s mode_select(hold0): observed %b expected %b", tag, mode_b, exp);
        end
    endtask

    task automatic check_led(input string tag, input logic exp_a, input logic exp_b);
        n_checks++;
        assert (led_a === exp_a) else begin
            n_fails++;
            $error("FAIL %s led(hold3): observed %b expected %b", tag, led_a, exp_a);
        end
        n_checks++;
        assert (led_b === exp_b) else begin
            n_fails++;
            $error("FAIL %s led(hold0): observed %b expected %b", tag, led_b, exp_b);
        end
    endtask

    task automatic press();
        btn = 1'b0;
        repeat (20) tick();
        btn = 1'b1;
        repeat (20) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [3:0] wrap_exp [9];
        wrap_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
                     4'b0100, 4'b1000, 4'b0001, 4'b0010};

        rst  = 1'b1;
        btn  = 1'b1;
        comm = 1'b0;
        repeat (2) tick();
        check_mode("reset", 4'b0001);
        check_led("reset", 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) tick();

        // Clean press: step lands on the ninth edge after the pin settles.
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_mode($sformatf("clean_press_edge%0d", i), (i < 9) ? 4'b0001 : 4'b0010);
        end
        repeat (10) tick();
        btn = 1'b1;
        repeat (20) tick();
        check_mode("clean_release", 4'b0010);

        // Short glitches only.
        for (int i = 0; i < 12; i++) begin
            btn = 1'b0;
            repeat ($urandom_range(1, 7)) tick();
            btn = 1'b1;
            repeat ($urandom_range(1, 7)) tick();
        end
        repeat (20) tick();
        check_mode("bounce_reject", 4'b0010);

        // Noisy press followed by noisy release: one step.
        for (int i = 0; i < 4; i++) begin
            btn = 1'b0;
            repeat ($urandom_range(1, 7)) tick();
            btn = 1'b1;
            repeat ($urandom_range(1, 7)) tick();
        end
        btn = 1'b0;
        repeat (12) tick();
        check_mode("noisy_press", 4'b0100);
        for (int i = 0; i < 4; i++) begin
            btn = 1'b1;
            repeat ($urandom_range(1, 7)) tick();
            btn = 1'b0;
            repeat ($urandom_range(1, 7)) tick();
        end
        btn = 1'b1;
        repeat (20) tick();
        check_mode("noisy_release", 4'b0100);

        // Wrap-around sequence from reset.
        do_reset();
        check_mode("wrap_reset", 4'b0001);
        for (int i = 0; i < 9; i++) begin
            press();
            check_mode($sformatf("wrap%0d", i), wrap_exp[i]);
        end

        // Long hold: no auto-repeat.
        btn = 1'b0;
        repeat (500) tick();
        check_mode("long_hold_mid", 4'b0100);
        repeat (500) tick();
        check_mode("long_hold_end", 4'b0100);
        btn = 1'b1;
        repeat (20) tick();
        check_mode("long_hold_release", 4'b0100);

        // Reset while held, release during reset: no step afterwards.
        btn = 1'b0;
        repeat (20) tick();
        check_mode("pre_reset_hold", 4'b1000);
        rst = 1'b1;
        repeat (3) tick();
        check_mode("reset_mid_hold", 4'b0001);
        btn = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        check_mode("after_reset_release", 4'b0001);

        // Activity LED, with a simultaneous press on the button path.
        check_led("led_idle", 1'b0, 1'b0);
        comm = 1'b1;
        btn  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_led($sformatf("led_edge%0d", i), (i <= 6), (i <= 3));
            if (i == 3) comm = 1'b0;
        end
        check_mode("press_during_led", 4'b0010);
        btn = 1'b1;
        repeat (20) tick();
        check_mode("release_after_led", 4'b0010);
        check_led("led_final", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
